rat_intr_ctrl: RTL and testbench

Parametrised multi-source interrupt controller for the RAT CPU. It sits between N peripheral interrupt lines and the control unit's single `interrupt` input. It latches edge-triggered requests, applies a per-source mask and a global enable, and arbitrates by fixed priority. It presents one request plus a per-source vector address to the control unit, and tracks in-service sources until return-from-interrupt.

---
 rtl/rat_intr_pkg.sv | 21 ++
 rtl/rat_prio_enc.sv | 21 ++
 rtl/rat_intr_ctrl.sv | 126 ++++++++++++
 tb/tb_rat_intr_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_intr_pkg.sv
// Shared state encoding and priority helper for the RAT interrupt controller.
package rat_intr_pkg;
  localparam int MAX_SRC   = 8;
  localparam int MAX_IDX_W = $clog2(MAX_SRC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  // Index of the least-significant set bit; 0 when nothing is set.
  function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/rat_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module rat_prio_enc
  import rat_intr_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [MAX_SRC-1:0]   req_ext;
  logic [MAX_IDX_W-1:0] low;

  assign req_ext = MAX_SRC'(req);
  assign low     = lowest_set(req_ext);
  assign idx     = IDX_W'(low);
  assign valid   = |req;

endmodule

// File: rtl/rat_intr_ctrl.sv
// RAT multi-source interrupt controller: edge latch, mask, global enable, fixed priority.
// Define RAT_INTR_NEST_EN to let a higher-priority source preempt an active ISR.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int               NUM_SRC  = 4,
  parameter int               VEC_W    = 10,
  parameter logic [VEC_W-1:0] BASE_VEC = 10'h3FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_din,
  input  logic               i_set,
  input  logic               i_clr,
  input  logic               reti,
  input  logic               intr_ack,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic               gie
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e             state, state_nxt;
  logic [NUM_SRC-1:0] src_q, mask_q, pending_q, in_service_q;
  logic               gie_q;
  logic [IDX_W-1:0]   win_q, elig_idx, is_idx;
  logic               elig_vld, is_vld;
  logic [NUM_SRC-1:0] rise, allow, elig, win_oh, is_lo_oh;
  logic               req_live, ack_take;

  assign rise = src_irq & ~src_q;

  // In-service gating: nesting admits only sources above the active ISR's priority.
  always_comb begin
    allow = '0;
`ifdef RAT_INTR_NEST_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      allow[i] = !is_vld || (IDX_W'(i) < is_idx);
    end
`else
    allow = {NUM_SRC{!is_vld}};
`endif
  end

  assign elig = pending_q & ~mask_q & {NUM_SRC{gie_q}} & allow;

  rat_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .req   (elig),
    .idx   (elig_idx),
    .valid (elig_vld)
  );

  rat_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_isv (
    .req   (in_service_q),
    .idx   (is_idx),
    .valid (is_vld)
  );

  // A latched request stays live only while gie is set and its source unmasked.
  assign req_live = gie_q & ~mask_q[win_q];
  assign ack_take = (state == ST_REQ) & req_live & intr_ack;
  assign win_oh   = NUM_SRC'(1) << win_q;
  assign is_lo_oh = {NUM_SRC{is_vld}} & (NUM_SRC'(1) << is_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (elig_vld) state_nxt = ST_REQ;
      ST_REQ: begin
        if (!req_live) begin
          state_nxt = ST_IDLE;
        end else if (intr_ack) begin
`ifdef RAT_INTR_NEST_EN
          state_nxt = ST_IDLE;
`else
          state_nxt = ST_BUSY;
`endif
        end
      end
      ST_BUSY: if (reti) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    irq = 1'b0;
    if (state == ST_REQ) irq = req_live;
  end

  assign vector     = BASE_VEC - VEC_W'(win_q);
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign gie        = gie_q;

  // Edge history resets high so a line already asserted at release does not request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q        <= '1;
      mask_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      gie_q        <= 1'b0;
      win_q        <= '0;
    end else begin
      src_q <= src_irq;
      if (mask_wr) mask_q <= mask_din;
      if ((state == ST_IDLE) && elig_vld) win_q <= elig_idx;
      pending_q    <= (pending_q & ~({NUM_SRC{ack_take}} & win_oh)) | rise;
      in_service_q <= (in_service_q & ~({NUM_SRC{reti}} & is_lo_oh)) |
                      ({NUM_SRC{ack_take}} & win_oh);
      if (ack_take || i_clr) gie_q <= 1'b0;
      else if (i_set)        gie_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Randomized and directed bench for rat_intr_ctrl against a behavioural reference model.
module tb_rat_intr_ctrl;
  localparam int         NS    = 4;
  localparam int         VW    = 10;
  localparam logic [9:0] BASE  = 10'h3FF;
  localparam logic [9:0] BASE2 = 10'h001;
`ifdef RAT_INTR_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] src_irq, mask_din;
  logic          mask_wr, i_set, i_clr, reti, intr_ack;
  logic          irq, irq2, gie, gie2;
  logic [VW-1:0] vector, vector2;
  logic [NS-1:0] pending, pending2, in_service, in_service2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rat_intr_ctrl #(.NUM_SRC(NS), .VEC_W(VW), .BASE_VEC(BASE)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .mask_wr(mask_wr), .mask_din(mask_din),
    .i_set(i_set), .i_clr(i_clr), .reti(reti), .intr_ack(intr_ack),
    .irq(irq), .vector(vector), .pending(pending), .in_service(in_service), .gie(gie)
  );

  rat_intr_ctrl #(.NUM_SRC(NS), .VEC_W(VW), .BASE_VEC(BASE2)) dut_wrap (
    .clk(clk), .reset(reset), .src_irq(src_irq), .mask_wr(mask_wr), .mask_din(mask_din),
    .i_set(i_set), .i_clr(i_clr), .reti(reti), .intr_ack(intr_ack),
    .irq(irq2), .vector(vector2), .pending(pending2), .in_service(in_service2), .gie(gie2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: request flag, latched winner, busy flag and plain bit sets.
  bit [NS-1:0] m_pend, m_mask, m_is, m_prev;
  bit          m_gie, m_req, m_busy;
  int          m_win;

  function automatic bit m_irq();
    return m_req && m_gie && !m_mask[m_win];
  endfunction

  function automatic int m_vec(input int base);
    return (base - m_win) & ((1 << VW) - 1);
  endfunction

  function automatic bit eligible(input int i);
    bit ok_isv;
    ok_isv = NEST ? ((int'(m_is) & ((2 << i) - 1)) == 0) : (m_is == '0);
    return m_pend[i] && !m_mask[i] && m_gie && ok_isv;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_is = '0; m_prev = '1;
      m_gie = 1'b0; m_req = 1'b0; m_busy = 1'b0; m_win = 0;
    end else begin : upd
      bit          live, take, done;
      bit [NS-1:0] is_n, pend_n;
      int          w;
      live = m_irq();
      take = live && intr_ack;
      is_n = m_is;
      done = 1'b0;
      if (reti) begin
        for (int i = 0; i < NS; i++) begin
          if (!done && is_n[i]) begin
            is_n[i] = 1'b0;
            done = 1'b1;
          end
        end
      end
      if (take) is_n[m_win] = 1'b1;
      pend_n = m_pend;
      if (take) pend_n[m_win] = 1'b0;
      pend_n = pend_n | (src_irq & ~m_prev);
      if (!m_req && !m_busy) begin
        w = -1;
        for (int i = NS - 1; i >= 0; i--) if (eligible(i)) w = i;
        if (w >= 0) begin
          m_req = 1'b1;
          m_win = w;
        end
      end else if (m_req) begin
        if (!live) m_req = 1'b0;
        else if (take) begin
          m_req  = 1'b0;
          m_busy = !NEST;
        end
      end else if (reti) begin
        m_busy = 1'b0;
      end
      if (i_set) m_gie = 1'b1;
      if (i_clr) m_gie = 1'b0;
      if (take)  m_gie = 1'b0;
      if (mask_wr) m_mask = mask_din;
      m_prev = src_irq;
      m_pend = pend_n;
      m_is   = is_n;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("irq", irq, m_irq());
      chk("vector", vector, m_vec(int'(BASE)));
      chk("pending", pending, m_pend);
      chk("in_service", in_service, m_is);
      chk("gie", gie, m_gie);
      chk("irq_wrap", irq2, m_irq());
      chk("vector_wrap", vector2, m_vec(int'(BASE2)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic p_set();  i_set = 1'b1;    cyc(1); i_set = 1'b0;    endtask
  task automatic p_clr();  i_clr = 1'b1;    cyc(1); i_clr = 1'b0;    endtask
  task automatic p_ack();  intr_ack = 1'b1; cyc(1); intr_ack = 1'b0; endtask
  task automatic p_reti(); reti = 1'b1;     cyc(1); reti = 1'b0;     endtask
  task automatic p_mask(input logic [NS-1:0] m);
    mask_wr = 1'b1; mask_din = m; cyc(1); mask_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; mask_din = '0; mask_wr = 1'b0;
    i_set = 1'b0; i_clr = 1'b0; reti = 1'b0; intr_ack = 1'b0;
    cyc(3);
    chk("rst_irq", irq, 1'b0);
    chk("rst_vector", vector, 10'h3FF);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_in_service", in_service, 4'b0000);
    chk("rst_gie", gie, 1'b0);
    reset = 1'b0;
    cyc(1);

    // single source 2
    p_set();
    chk("t1_gie", gie, 1'b1);
    src_irq = 4'b0100; cyc(1);
    chk("t1_pending", pending, 4'b0100);
    chk("t1_irq_early", irq, 1'b0);
    cyc(1);
    chk("t1_irq", irq, 1'b1);
    chk("t1_vector", vector, 10'h3FD);
    p_ack();
    chk("t1_irq_ack", irq, 1'b0);
    chk("t1_pending_ack", pending, 4'b0000);
    chk("t1_isv_ack", in_service, 4'b0100);
    chk("t1_gie_ack", gie, 1'b0);
    src_irq = '0;
    p_reti();
    chk("t1_isv_reti", in_service, 4'b0000);

    // simultaneous sources 1 and 3
    p_set();
    src_irq = 4'b1010; cyc(2);
    chk("t2_irq", irq, 1'b1);
    chk("t2_vector", vector, 10'h3FE);
    chk("t2_vector_wrap", vector2, 10'h000);
    p_ack();
    chk("t2_isv", in_service, 4'b0010);
    src_irq = '0;
    p_reti();
    p_set();
    cyc(1);
    chk("t2_irq_next", irq, 1'b1);
    chk("t2_vector_next", vector, 10'h3FC);
    chk("t2_vector_wrap3", vector2, 10'h3FE);
    p_ack();
    p_reti();

    // masked source 0
    p_mask(4'b0001);
    p_set();
    src_irq = 4'b0001; cyc(2);
    chk("t3_irq_masked", irq, 1'b0);
    chk("t3_pending", pending, 4'b0001);
    p_mask(4'b0000);
    chk("t3_irq_unmask_early", irq, 1'b0);
    cyc(1);
    chk("t3_irq", irq, 1'b1);
    chk("t3_vector", vector, 10'h3FF);

    // withdraw on gie clear, then re-request
    p_clr();
    chk("t4_irq_clr", irq, 1'b0);
    chk("t4_pending", pending, 4'b0001);
    p_set();
    cyc(1);
    chk("t4_irq_again", irq, 1'b1);
    chk("t4_vector_again", vector, 10'h3FF);
    p_ack();
    src_irq = '0;
    p_reti();

    // requests while source 2 is in service
    p_set();
    src_irq = 4'b0100; cyc(2);
    p_ack();
    src_irq = '0;
    p_set();
    chk("t5_isv", in_service, 4'b0100);
    src_irq = 4'b1000; cyc(2);
    chk("t5_irq_src3", irq, 1'b0);
    chk("t5_pending_src3", pending, 4'b1000);
    src_irq = 4'b1001; cyc(2);
`ifdef RAT_INTR_NEST_EN
    chk("t5_irq_nest", irq, 1'b1);
    chk("t5_vector_nest", vector, 10'h3FF);
`else
    chk("t5_irq_busy", irq, 1'b0);
    chk("t5_pending_busy", pending, 4'b1001);
    p_reti();
    cyc(1);
    chk("t5_irq_after_reti", irq, 1'b1);
    chk("t5_vector_after_reti", vector, 10'h3FF);
`endif

    // asynchronous reset during a request
    src_irq = 4'b1111;
    reset = 1'b1;
    #1;
    chk("t6_irq_async", irq, 1'b0);
    chk("t6_pending", pending, 4'b0000);
    chk("t6_isv", in_service, 4'b0000);
    chk("t6_gie", gie, 1'b0);
    chk("t6_vector", vector, 10'h3FF);
    cyc(2);
    reset = 1'b0;
    p_set();
    cyc(3);
    chk("t6_no_req_high_line", pending, 4'b0000);
    chk("t6_no_irq_high_line", irq, 1'b0);
    src_irq = '0;
    cyc(1);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 5) == 0) src_irq[b] = ~src_irq[b];
      end
      mask_wr  = ($urandom_range(0, 15) == 0);
      mask_din = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      i_set    = ($urandom_range(0, 5) == 0);
      i_clr    = ($urandom_range(0, 19) == 0);
      reti     = ($urandom_range(0, 9) == 0);
      intr_ack = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      reset    = (k % 1500 == 1499);
      cyc(1);
    end
    reset = 1'b0; src_irq = '0; mask_wr = 1'b0; i_set = 1'b0;
    i_clr = 1'b0; reti = 1'b0; intr_ack = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
